sub32_serial: RTL
=================

# sub32_serial

Multi-cycle 32-bit subtractor computing d = a − b − bi four bits per clock, the inverse-direction companion to the team's 32-bit carry look-ahead adder. It trades latency for area: one 4-bit borrow-ripple slice is reused over eight cycles under a small FSM with a start/busy/done handshake. It sits beside the adder in the arithmetic datapath wherever a subtract or compare result is needed and the extra cycles are acceptable.

## Interface
- No parameters; width fixed at 32 bits, slice fixed at 4 bits (8 slices).
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only when state is IDLE or DONE.
- a  in  32  minuend, captured on the accepted start edge.
- b  in  32  subtrahend, captured on the accepted start edge.
- bi  in  1  borrow-in, captured on the accepted start edge.
- d  out  32  difference, registered, updated only at completion.
- bo  out  1  borrow-out (1 when a < b + bi unsigned), registered.
- zero  out  1  d == 0, registered with d.
- ovf  out  1  signed overflow, registered with d.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse, result valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b, bi into operand registers; set slice counter cnt=0; set running borrow = bi; go to RUN. start=0 → stay in IDLE.
- RUN: each cycle processes slice cnt (bits 4·cnt+3 : 4·cnt).
  - Slice arithmetic: {c, r} = a_slice + ~b_slice + ~borrow (5-bit result); borrow ← ~c.
  - r shifts into the partial-result register; cnt increments.
- After slice 7 (cnt = 7):
  - load d with the full partial result and bo with the final borrow;
  - zero ← (result == 0);
  - ovf ← (a[31] != b[31]) && (d[31] != a[31]), computed on the latched operands;
  - go to DONE.
- DONE: done=1. start=1 → accept new operands exactly as in IDLE and go to RUN. start=0 → go to IDLE.
- start in RUN is ignored; no queuing and no effect on the operation in progress.
- d, bo, zero and ovf hold their last completed values through IDLE and through any later RUN until the next completion.
- Arithmetic is modulo 2^32. The result must equal a + ~b + ~bi truncated to 32 bits, with bo = ~carry-out.

## Timing
- Reset (rst=1 at a rising edge) puts the block in IDLE.
- Reset values of every output: d=0, bo=0, zero=0, ovf=0, busy=0, done=0. Internal counter, borrow and operand registers clear to 0.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, outputs go to their reset values on that edge.
- Latency: start sampled at edge E0 → busy=1 from E0 through E8 → slices 0..7 processed at edges E1..E8.
  - d, bo, zero and ovf update at E8.
  - done=1 for the cycle between E8 and E9.
- busy and done are never high together.
- Back-to-back throughput: start held high in DONE gives one result every 9 cycles.
- Operand inputs may change freely after the accepted start edge; only the latched copies are used.

## Test plan
- Reset, then a=0, b=0, bi=0 → done exactly 9 edges after start; d=0x00000000, bo=0, zero=1, ovf=0.
- a=0x00000000, b=0x00000001, bi=0 → d=0xFFFFFFFF, bo=1, zero=0, ovf=0. Then a=0x80000000, b=0x00000001 → d=0x7FFFFFFF, bo=0, ovf=1.
- a=0x35315986, b=0x12345678, bi=0 → d=0x22FD030E, bo=0. Then a=0x0000FFFF, b=0x0000FFFF, bi=1 → d=0xFFFFFFFF, bo=1.
- Start pulsed again at cycles 3 and 5 of RUN with different operands → ignored; the first result completes unchanged and busy stays high for exactly 9 edges.
- rst asserted at RUN cycle 4 → next edge gives state IDLE, busy=0, d=0, no done pulse. A fresh start then completes correctly.
- start held high continuously through two operations → done pulses 9 cycles apart. The second result reflects the operands present at the DONE-cycle start edge; d holds the first result until the second completion.

Source files
------------

// File: rtl/sub32_serial.sv
// Multi-cycle 32-bit subtractor: d = a - b - bi, one 4-bit borrow-ripple slice per clock
// over eight cycles, with a start/busy/done handshake.
module sub32_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bi,
    output logic [31:0] d,
    output logic        bo,
    output logic        zero,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic        borrow;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc;

    logic [3:0]  a_sl;
    logic [3:0]  b_sl;
    logic [4:0]  sum;
    logic [31:0] result;
    logic        accept;

    // Subtraction as a + ~b + ~borrow; the carry out of the slice is the inverted borrow.
    always_comb begin
        a_sl   = a_q[{cnt, 2'b00} +: 4];
        b_sl   = b_q[{cnt, 2'b00} +: 4];
        sum    = {1'b0, a_sl} + {1'b0, ~b_sl} + {4'b0000, ~borrow};
        result = {sum[3:0], acc[31:4]};
        accept = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            borrow <= 1'b0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            acc    <= 32'd0;
            d      <= 32'd0;
            bo     <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bi;
                        cnt    <= 3'd0;
                        acc    <= 32'd0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    // Slice results enter at the top so slice 0 ends up in bits 3:0.
                    acc    <= result;
                    borrow <= ~sum[4];
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        d     <= result;
                        bo    <= ~sum[4];
                        zero  <= (result == 32'd0);
                        ovf   <= (a_q[31] != b_q[31]) && (result[31] != a_q[31]);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
